// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand forwarding from EX/WB, load-use stall and bubble insertion.
// Optional performance counters are enabled with `define ID_EX_PERF_EN.
module id_ex_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic [XLEN-1:0]       id_rs1_data_i,
  input  logic [XLEN-1:0]       id_rs2_data_i,
  input  logic [XLEN-1:0]       id_imm_i,
  input  logic                  id_use_imm_i,
  input  logic [2:0]            id_alu3_i,
  input  logic [6:0]            id_alu7_i,
  input  logic                  id_reg_write_i,
  input  logic                  id_mem_read_i,
  input  logic [XLEN-1:0]       ex_result_i,
  input  logic                  wb_valid_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0]       wb_data_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  ex_valid_o,
  output logic [XLEN-1:0]       ex_src1_o,
  output logic [XLEN-1:0]       ex_src2_o,
  output logic [XLEN-1:0]       ex_rs2_data_o,
  output logic [2:0]            ex_alu3_o,
  output logic [6:0]            ex_alu7_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic                  ex_reg_write_o,
  output logic                  ex_mem_read_o
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           bubble_cnt_o
`endif
);

  localparam logic [2:0] ALU3_ADD   = 3'b000;
  localparam logic [6:0] ALU7_I_STD = 7'b0000000;

  logic                  r_valid;
  logic                  r_reg_write;
  logic                  r_mem_read;
  logic [XLEN-1:0]       r_src1;
  logic [XLEN-1:0]       r_src2;
  logic [XLEN-1:0]       r_rs2_data;
  logic [2:0]            r_alu3;
  logic [6:0]            r_alu7;
  logic [REG_ADDR_W-1:0] r_rd;

  logic                  w_ex_fwd_en;
  logic                  w_hazard;
  logic                  w_bubble;
  logic [XLEN-1:0]       w_fwd1;
  logic [XLEN-1:0]       w_fwd2;

  // A load in EX has no result yet, so it never forwards from EX; bubbles never forward.
  assign w_ex_fwd_en = r_valid & r_reg_write & ~r_mem_read;

  always_comb begin
    w_fwd1 = id_rs1_data_i;
    if (id_rs1_i == '0)
      w_fwd1 = '0;
    else if (w_ex_fwd_en && (r_rd == id_rs1_i))
      w_fwd1 = ex_result_i;
    else if (wb_valid_i && (wb_rd_i == id_rs1_i))
      w_fwd1 = wb_data_i;
  end

  always_comb begin
    w_fwd2 = id_rs2_data_i;
    if (id_rs2_i == '0)
      w_fwd2 = '0;
    else if (w_ex_fwd_en && (r_rd == id_rs2_i))
      w_fwd2 = ex_result_i;
    else if (wb_valid_i && (wb_rd_i == id_rs2_i))
      w_fwd2 = wb_data_i;
  end

  assign w_hazard = id_valid_i & r_valid & r_mem_read & (r_rd != '0) &
                    ((r_rd == id_rs1_i) | ((r_rd == id_rs2_i) & ~id_use_imm_i));
  assign w_bubble = flush_i | w_hazard;
  assign stall_o  = w_hazard & ~flush_i;

  // Data fields are captured even for bubbles; only the control bits are cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_src1      <= '0;
      r_src2      <= '0;
      r_rs2_data  <= '0;
      r_alu3      <= ALU3_ADD;
      r_alu7      <= ALU7_I_STD;
      r_rd        <= '0;
    end else begin
      r_src1     <= w_fwd1;
      r_src2     <= id_use_imm_i ? id_imm_i : w_fwd2;
      r_rs2_data <= w_fwd2;
      r_alu3     <= id_alu3_i;
      r_alu7     <= id_alu7_i;
      r_rd       <= id_rd_i;
      if (w_bubble) begin
        r_valid     <= 1'b0;
        r_reg_write <= 1'b0;
        r_mem_read  <= 1'b0;
      end else begin
        r_valid     <= id_valid_i;
        r_reg_write <= id_reg_write_i & id_valid_i;
        r_mem_read  <= id_mem_read_i & id_valid_i;
      end
    end
  end

  assign ex_valid_o     = r_valid;
  assign ex_reg_write_o = r_reg_write;
  assign ex_mem_read_o  = r_mem_read;
  assign ex_src1_o      = r_src1;
  assign ex_src2_o      = r_src2;
  assign ex_rs2_data_o  = r_rs2_data;
  assign ex_alu3_o      = r_alu3;
  assign ex_alu7_o      = r_alu7;
  assign ex_rd_o        = r_rd;

`ifdef ID_EX_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (stall_o)
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_bubble)
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign stall_cnt_o  = r_stall_cnt;
  assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule
